// File: rtl/std_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit std_reg among NUM_REQ requesters, one write per cycle.
// Optional owner lock for back-to-back writes: define STD_REG_ARB_LOCK_EN.
module std_reg_arbiter #(
    parameter int WIDTH   = 7,
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] in,
`ifdef STD_REG_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       lock,
`endif
    output logic [NUM_REQ-1:0]       grant,
    output logic [WIDTH-1:0]         out,
    output logic [NUM_REQ-1:0]       done,
    output logic [IDX_W-1:0]         last_writer
);

    localparam logic [IDX_W:0]   NREQ = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] elig;
    logic               gnt_any;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W:0]     cand;
    logic [WIDTH-1:0]   wdata;

`ifdef STD_REG_ARB_LOCK_EN
    logic             own_vld;
    logic [IDX_W-1:0] owner;
    logic             own_hold;

    // An owner that still requests bypasses done masking; dropping req releases it at once.
    assign own_hold = own_vld && req[owner];
    assign elig     = own_hold ? (NUM_REQ'(1) << owner) : (req & ~done);
`else
    assign elig = req & ~done;
`endif

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        grant   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= NREQ) cand = cand - NREQ;
            if (!gnt_any && reset && elig[cand[IDX_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
        if (gnt_any) grant[gnt_idx] = 1'b1;
    end

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) wdata = in[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out         <= '0;
            done        <= '0;
            last_writer <= '0;
            ptr         <= '0;
        end else begin
            // grant is one-hot or zero, so it is exactly next cycle's done.
            done <= grant;
            if (gnt_any) begin
                out         <= wdata;
                last_writer <= gnt_idx;
                ptr         <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

`ifdef STD_REG_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            own_vld <= 1'b0;
            owner   <= '0;
        end else if (gnt_any) begin
            own_vld <= lock[gnt_idx];
            owner   <= gnt_idx;
        end else begin
            own_vld <= 1'b0;
        end
    end
`endif

endmodule
